// File: rtl/adv_pkg.sv
// Shared types for the adventure-game autoplayer: move directions, run outcome
// and player FSM states, plus the direction-to-pulse decode.
package adv_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_WON     = 2'd1,
    RES_DIED    = 2'd2,
    RES_STALLED = 2'd3
  } result_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_GAP    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Pulse vector ordered {n, s, e, w}.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] v;
    case (d)
      DIR_N:   v = 4'b1000;
      DIR_S:   v = 4'b0100;
      DIR_E:   v = 4'b0010;
      default: v = 4'b0001;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/adv_script_mem.sv
// Move script storage: DEPTH entries of one direction each, synchronous write,
// asynchronous read. Deliberately not reset so a script survives a board reset.
module adv_script_mem
  import adv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  dir_t                     wr_dir,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output dir_t                     rd_dir
);

  dir_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dir;
    end
  end

  assign rd_dir = mem_q[rd_addr];

endmodule

// File: rtl/adv_autoplayer.sv
// Scripted player: replays the stored moves as one-hot n/s/e/w pulses spaced by
// idle gaps, watches the game's win/die and reports WON, DIED or STALLED.
module adv_autoplayer
  import adv_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [1:0]                 wr_dir,
  input  logic [$clog2(DEPTH+1)-1:0] len,
  input  logic                       start,
  input  logic                       win,
  input  logic                       die,
  output logic                       n,
  output logic                       s,
  output logic                       e,
  output logic                       w,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 result,
  output logic [$clog2(DEPTH+1)-1:0] moves
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH + 1);
  localparam int CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  state_t          state_q;
  logic [3:0]      pulse_q;
  logic            busy_q;
  logic            done_q;
  result_t         result_q;
  logic [LW-1:0]   moves_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;

  logic            mem_we_d;
  logic [LW-1:0]   len_clamp_d;
  dir_t            rd_dir;
  dir_t            first_dir_d;

  assign mem_we_d    = wr_en && !busy_q;
  assign len_clamp_d = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

  adv_script_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we_d),
    .wr_addr (wr_addr),
    .wr_dir  (dir_t'(wr_dir)),
    .rd_addr (idx_q[AW-1:0]),
    .rd_dir  (rd_dir)
  );

  // The first pulse is loaded on the start edge, so a same-cycle write to
  // entry 0 has to be forwarded past the not-yet-updated array.
  assign first_dir_d = (mem_we_d && (wr_addr == '0)) ? dir_t'(wr_dir) : rd_dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pulse_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= RES_NONE;
      moves_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      pulse_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q    <= len_clamp_d;
            result_q <= RES_NONE;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (len_clamp_d == '0) begin
              moves_q <= '0;
              idx_q   <= '0;
              state_q <= ST_SETTLE;
            end else begin
              pulse_q <= dir_onehot(first_dir_d);
              moves_q <= LW'(1);
              idx_q   <= LW'(1);
              state_q <= ST_DRIVE;
            end
          end
        end

        ST_DRIVE, ST_GAP, ST_SETTLE: begin
          // Game outcome overrides any scheduled move or timeout; win beats die.
          if (win || die) begin
            result_q <= win ? RES_WON : RES_DIED;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_DONE;
          end else if (state_q == ST_DRIVE) begin
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else if (state_q == ST_GAP) begin
            if (cnt_q == CW'(GAP - 1)) begin
              cnt_q <= '0;
              if (idx_q == len_q) begin
                state_q <= ST_SETTLE;
              end else begin
                pulse_q <= dir_onehot(rd_dir);
                moves_q <= moves_q + LW'(1);
                idx_q   <= idx_q + LW'(1);
                state_q <= ST_DRIVE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
              result_q <= RES_STALLED;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        ST_DONE: begin
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign {n, s, e, w} = pulse_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign moves        = moves_q;

endmodule

// File: tb/tb_adv_autoplayer.sv
// Bench for adv_autoplayer driving a small behavioural adventure game; expected
// outcomes come from a timeline model of scripted moves through that game.
module tb_adv_autoplayer;
  import adv_pkg::*;

  localparam int DEPTH   = 16;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;
  localparam int AW      = 4;
  localparam int LW      = 5;

  // Game rooms; bit 4 of the game state word holds the sword.
  localparam int R_CAVE   = 0;
  localparam int R_TUNNEL = 1;
  localparam int R_RIVER  = 2;
  localparam int R_STASH  = 3;
  localparam int R_DRAGON = 4;
  localparam int R_WIN    = 5;
  localparam int R_DEAD   = 6;
  localparam int R_TRASH  = 7;
  localparam int R_SWORD  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [1:0]    wr_dir = '0;
  logic [LW-1:0] len = '0;
  logic          start = 1'b0;
  logic          win, die;
  logic          n, s, e, w, busy, done;
  logic [1:0]    result;
  logic [LW-1:0] moves;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int done_cnt, done_cyc, done_res, done_moves, onehot_bad;
  int pc_q[$];
  int pd_q[$];
  int exp_pc[$];
  int exp_pd[$];
  int exp_res, exp_mv, exp_done_c;
  int script [DEPTH];
  int game_q;

  always #5 clk = ~clk;

  adv_autoplayer #(
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dir  (wr_dir),
    .len     (len),
    .start   (start),
    .win     (win),
    .die     (die),
    .n       (n),
    .s       (s),
    .e       (e),
    .w       (w),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .moves   (moves)
  );

  function automatic int pcode(input logic [3:0] p);
    case (p)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      4'b0001: return 3;
      default: return -1;
    endcase
  endfunction

  // One clock of the game: d is -1 for no move, else 0..3 = N,S,E,W.
  function automatic int game_step(input int g, input int d);
    int room;
    int sw;
    room = g & 15;
    sw   = (g >> 4) & 1;
    case (room)
      R_CAVE:   if (d == 2) room = R_TUNNEL; else if (d == 0) room = R_TRASH;
      R_TRASH:  if (d == 1) room = R_CAVE; else begin room = R_SWORD; sw = 1; end
      R_SWORD:  if (d == 2) room = R_RIVER;
      R_TUNNEL: if (d == 1) room = R_RIVER; else if (d == 3) room = R_CAVE;
      R_RIVER:  if (d == 3) begin room = R_STASH; sw = 1; end
                else if (d == 2) room = R_DRAGON;
                else if (d == 0) room = R_TUNNEL;
      R_STASH:  if (d == 2) room = R_RIVER;
      R_DRAGON: room = (sw != 0) ? R_WIN : R_DEAD;
      default:  room = room;
    endcase
    return room | (sw << 4);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) game_q <= R_CAVE;
    else          game_q <= game_step(game_q, pcode({n, s, e, w}));
  end
  assign win = ((game_q & 15) == R_WIN);
  assign die = ((game_q & 15) == R_DEAD);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if ($countones({n, s, e, w}) > 1) onehot_bad++;
      if (|{n, s, e, w}) begin
        pc_q.push_back(cyc);
        pd_q.push_back(pcode({n, s, e, w}));
      end
      if (done) begin
        done_cnt++;
        done_cyc   = cyc;
        done_res   = int'(result);
        done_moves = int'(moves);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Timeline model: cycle c=0 is the first cycle after start; a move goes out
  // every GAP+1 cycles, then TIMEOUT cycles of waiting; the game is observed every cycle.
  task automatic model(input int L);
    int g, lc, per, pulse, c_end;
    lc  = (L > DEPTH) ? DEPTH : L;
    per = GAP + 1;
    g   = R_CAVE;
    exp_mv = 0;
    exp_res = int'(RES_NONE);
    c_end = 0;
    exp_pc.delete();
    exp_pd.delete();
    for (int c = 0; c < 1000; c++) begin
      pulse = -1;
      if (c < lc * per && (c % per) == 0) pulse = script[c / per];
      if (pulse >= 0) begin
        exp_pc.push_back(c);
        exp_pd.push_back(pulse);
        exp_mv++;
      end
      c_end = c;
      if ((g & 15) == R_WIN) begin exp_res = int'(RES_WON); break; end
      if ((g & 15) == R_DEAD) begin exp_res = int'(RES_DIED); break; end
      if (c - lc * per == TIMEOUT - 1) begin exp_res = int'(RES_STALLED); break; end
      g = game_step(g, pulse);
    end
    exp_done_c = c_end + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run(input string tag, input int L, input bit do_write, input bit poke);
    int lc, t, start_cyc, mism;
    lc = (L > DEPTH) ? DEPTH : L;
    do_reset();
    if (do_write) begin
      for (int i = 1; i < lc; i++) begin
        wr_en   = 1'b1;
        wr_addr = AW'(i);
        wr_dir  = 2'(script[i]);
        @(negedge clk);
      end
    end
    // Entry 0 is written in the same cycle as start.
    wr_en    = do_write && (lc > 0);
    wr_addr  = '0;
    wr_dir   = 2'(script[0]);
    start    = 1'b1;
    len      = LW'(L);
    pc_q.delete();
    pd_q.delete();
    done_cnt   = 0;
    onehot_bad = 0;
    done_cyc   = 0;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    if (poke) begin
      repeat (3) @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_dir  = ~2'(script[0]);
      start   = 1'b1;
      len     = LW'(1);
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'(1));
    repeat (4) @(negedge clk);
    model(L);
    chk({tag, "_done_once"}, 32'(done_cnt), 32'(1));
    chk({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(exp_done_c + 1));
    chk({tag, "_result"}, 32'(done_res), 32'(exp_res));
    chk({tag, "_moves"}, 32'(done_moves), 32'(exp_mv));
    chk({tag, "_result_held"}, 32'(result), 32'(exp_res));
    chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
    chk({tag, "_onehot"}, 32'(onehot_bad), 32'(0));
    chk({tag, "_pulse_cnt"}, 32'(pc_q.size()), 32'(exp_pc.size()));
    mism = 0;
    for (int i = 0; i < pc_q.size() && i < exp_pc.size(); i++) begin
      if (pc_q[i] - start_cyc - 1 != exp_pc[i] || pd_q[i] != exp_pd[i]) mism++;
    end
    chk({tag, "_pulse_seq"}, 32'(mism), 32'(0));
    $display("run %s len=%0d result=%0d moves=%0d done_after=%0d pulses=%0d",
             tag, L, done_res, done_moves, done_cyc - start_cyc, pc_q.size());
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pulses", 32'({n, s, e, w}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(RES_NONE));
    chk("rst_moves", 32'(moves), 32'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'(0));

    // 1: E,S,W,E,E via the stash -> won
    script[0] = 2; script[1] = 1; script[2] = 3; script[3] = 2; script[4] = 2;
    run("case1", 5, 1, 0);
    chk("case1_won", 32'(done_res), 32'(RES_WON));

    // 5: start and write while busy are ignored; script unchanged afterwards
    run("case5_poke", 5, 0, 1);
    run("case5_after", 5, 0, 0);
    chk("case5_won", 32'(done_res), 32'(RES_WON));

    // 6: reset during the gap after move 2
    do_reset();
    start = 1'b1;
    len   = LW'(5);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_moves", 32'(moves), 32'(2));
    chk("abort_pre_busy", 32'(busy), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("abort_pulses", 32'({n, s, e, w}), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_result", 32'(result), 32'(RES_NONE));
    chk("abort_moves", 32'(moves), 32'(0));
    @(negedge clk);
    chk("abort_hold", 32'({n, s, e, w, busy, done}), 32'(0));
    reset_n = 1'b1;
    run("case6_rerun", 5, 0, 0);
    chk("case6_won", 32'(done_res), 32'(RES_WON));

    // 2: E,S,E straight to the dragon -> died
    script[0] = 2; script[1] = 1; script[2] = 2;
    run("case2", 3, 1, 0);
    chk("case2_died", 32'(done_res), 32'(RES_DIED));

    // 3: N,E,E picks up the sword in the trash during the gap -> won
    script[0] = 0; script[1] = 2; script[2] = 2;
    run("case3", 3, 1, 0);
    chk("case3_won", 32'(done_res), 32'(RES_WON));

    // 4: single move then timeout; len=0 times out with no moves
    script[0] = 2;
    run("case4", 1, 1, 0);
    chk("case4_stalled", 32'(done_res), 32'(RES_STALLED));
    run("case4_len0", 0, 1, 0);
    chk("case4_len0_moves", 32'(done_moves), 32'(0));

    // Randomized scripts, including len beyond DEPTH
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) script[i] = int'($urandom_range(0, 3));
      run("rand", int'($urandom_range(0, 20)), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
